alu_issue_seq: RTL
==================

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 in_valid  in  1  instruction/operand bundle valid.
REQ-005 in_ready  out  1  block can accept a bundle; high only in IDLE.
REQ-006 instr  in  32  MIPS instruction word; opcode [31:26], shamt [10:6], funct [5:0], imm [15:0].
REQ-007 rs_val, rt_val  in  32 each  register-file operands.
REQ-008 alu_a, alu_b  out  32 each  registered ALU operand drives.
REQ-009 alu_ctl  out  4  registered ALU control code.
REQ-010 alu_result  in  32; alu_zero  in  1  combinational ALU response to alu_a/alu_b/alu_ctl.
REQ-011 out_valid  out  1; out_ready  in  1  result handshake.
REQ-012 out_result  out  32; out_zero  out  1; out_illegal  out  1  registered result bundle.

Function
REQ-013 Accept when in_valid && in_ready on a rising edge; decode and load alu_a, alu_b, alu_ctl, shift count on that edge.
REQ-014 R-type (opcode 0x00) funct -> ctl: 0x24 AND 0000, 0x25 OR 0001, 0x21 ADDU 0010, 0x20 ADD 1010, 0x23 SUBU 0110, 0x22 SUB 1110, 0x26 XOR 0101, 0x2A SLT 0111, 0x2B SLTU 1111; a=rs_val, b=rt_val.
REQ-015 I-type: ADDI 0x08 -> 1010, ADDIU 0x09 -> 0010, SLTI 0x0A -> 0111, SLTIU 0x0B -> 1111 with b=sign-extended imm; ANDI 0x0C -> 0000, ORI 0x0D -> 0001, XORI 0x0E -> 0101 with b=zero-extended imm; a=rs_val.
REQ-016 BEQ 0x04 and BNE 0x05 -> 0110, a=rs_val, b=rt_val; out_zero carries the compare.
REQ-017 SLL funct 0x00 -> 0011, SRL funct 0x02 -> 0100; a=0, b=rt_val, count=shamt; the ALU shifts by one per cycle, so the block iterates.
REQ-018 Shift with shamt=0: issue ctl 0001 (OR) with a=0, b=rt_val, one EXEC cycle; result equals rt_val.
REQ-019 States IDLE, EXEC, DONE. IDLE->EXEC on accept of legal op; IDLE->DONE on accept of illegal op; EXEC->DONE when count<=1; DONE->IDLE when out_ready.
REQ-020 In EXEC with shift and count>1: alu_b <= alu_result, count decrements, ctl held, stay EXEC.
REQ-021 On EXEC->DONE: out_result <= alu_result, out_zero <= alu_zero, out_illegal <= 0.
REQ-022 Latency: out_valid high from accept edge +1 for non-shift ops and shamt<=1; accept edge +shamt for shamt>=2.
REQ-023 Illegal opcode/funct: out_result=0, out_zero=0, out_illegal=1, out_valid from accept edge; ALU drives unchanged.
REQ-024 out_valid high only in DONE; out_result/out_zero/out_illegal stable while out_valid && !out_ready.
REQ-025 No accept in DONE, even on the out_ready cycle; throughput one op per 3 cycles minimum.
REQ-026 alu_a/alu_b/alu_ctl hold last issued values in IDLE and DONE.

Reset
REQ-027 rst_n low: immediately state=IDLE, alu_a=0, alu_b=0, alu_ctl=0000, count=0, out_valid=0, out_result=0, out_zero=0, out_illegal=0.
REQ-028 Reset during EXEC or DONE aborts the op with no result; in_ready=1 on the first cycle after rst_n rises.

Structure
REQ-029 Shared package alu_issue_pkg holds ALU ctl code constants, opcode/funct constants, and the state enum.
REQ-030 One sub-module alu_ctl_decode: combinational instr -> ctl, operand-select, extension type, shift flag, legal.
REQ-031 The ALU itself is external; the bench instantiates the existing ALU on alu_a/alu_b/alu_ctl.

Verification
REQ-032 ADDU rs=5, rt=7 -> alu_ctl=0010, alu_a=5, alu_b=7; out_result=12, out_zero=0, out_valid at accept+1.
REQ-033 SLL shamt=4, rt=0x1 -> 4 EXEC cycles with ctl 0011; out_result=0x10 at accept+4.
REQ-034 BEQ rs=rt=0x1234 -> ctl 0110, out_result=0, out_zero=1.
REQ-035 ANDI imm=0xFFFF, rs=0xDEADBEEF -> alu_b=0x0000FFFF, out_result=0x0000BEEF; ADDI imm=0xFFFF -> alu_b=0xFFFFFFFF.
REQ-036 Opcode 0x3F -> out_illegal=1 at accept+0 edge, no EXEC; out_ready low 3 cycles -> outputs stable, in_ready=0.
REQ-037 rst_n low mid SLL shamt=31 -> all outputs at reset values immediately; in_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue sequencer: ALU control codes, MIPS
// opcode/funct values, sequencer states and the immediate-extension helper.
package alu_issue_pkg;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADDU = 4'b0010;
    localparam logic [3:0] CTL_SLL  = 4'b0011;
    localparam logic [3:0] CTL_SRL  = 4'b0100;
    localparam logic [3:0] CTL_XOR  = 4'b0101;
    localparam logic [3:0] CTL_SUBU = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_ADD  = 4'b1010;
    localparam logic [3:0] CTL_SUB  = 4'b1110;
    localparam logic [3:0] CTL_SLTU = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        B_RT   = 2'd0,
        B_SEXT = 2'd1,
        B_ZEXT = 2'd2
    } bsel_e;

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sign);
        return sign ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational MIPS instruction decode: ALU control code, operand-B source,
// operand-A forced to zero, shift flag and legality.
module alu_ctl_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  ctl_o,
    output bsel_e       b_sel_o,
    output logic        a_zero_o,
    output logic        shift_o,
    output logic        legal_o
);

    logic [5:0] opcode_s;
    logic [5:0] funct_s;
    logic [4:0] shamt_s;
    logic       unused_fields_s;

    assign opcode_s        = instr[31:26];
    assign funct_s         = instr[5:0];
    assign shamt_s         = instr[10:6];
    assign unused_fields_s = ^instr[25:11];

    // Opcode/funct decode; a zero-length shift becomes a pass-through OR of rt.
    always_comb begin
        ctl_o    = CTL_AND;
        b_sel_o  = B_RT;
        a_zero_o = 1'b0;
        shift_o  = 1'b0;
        legal_o  = 1'b1;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_AND:  ctl_o = CTL_AND;
                    FN_OR:   ctl_o = CTL_OR;
                    FN_ADDU: ctl_o = CTL_ADDU;
                    FN_ADD:  ctl_o = CTL_ADD;
                    FN_SUBU: ctl_o = CTL_SUBU;
                    FN_SUB:  ctl_o = CTL_SUB;
                    FN_XOR:  ctl_o = CTL_XOR;
                    FN_SLT:  ctl_o = CTL_SLT;
                    FN_SLTU: ctl_o = CTL_SLTU;
                    FN_SLL, FN_SRL: begin
                        a_zero_o = 1'b1;
                        shift_o  = 1'b1;
                        if (shamt_s == 5'd0) begin
                            ctl_o = CTL_OR;
                        end else begin
                            ctl_o = (funct_s == FN_SLL) ? CTL_SLL : CTL_SRL;
                        end
                    end
                    default: legal_o = 1'b0;
                endcase
            end
            OP_BEQ, OP_BNE: ctl_o = CTL_SUBU;
            OP_ADDI:  begin ctl_o = CTL_ADD;  b_sel_o = B_SEXT; end
            OP_ADDIU: begin ctl_o = CTL_ADDU; b_sel_o = B_SEXT; end
            OP_SLTI:  begin ctl_o = CTL_SLT;  b_sel_o = B_SEXT; end
            OP_SLTIU: begin ctl_o = CTL_SLTU; b_sel_o = B_SEXT; end
            OP_ANDI:  begin ctl_o = CTL_AND;  b_sel_o = B_ZEXT; end
            OP_ORI:   begin ctl_o = CTL_OR;   b_sel_o = B_ZEXT; end
            OP_XORI:  begin ctl_o = CTL_XOR;  b_sel_o = B_ZEXT; end
            default:  legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue sequencer in front of an external single-cycle ALU: decodes one
// instruction, drives registered operands, iterates shifts, returns the result.
module alu_issue_seq
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_illegal
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_ctl_q, alu_ctl_d;
    logic [4:0]        count_q, count_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        dec_ctl_s;
    bsel_e             dec_bsel_s;
    logic              dec_a_zero_s;
    logic              dec_shift_s;
    logic              dec_legal_s;
    logic              in_ready_s;
    logic              out_valid_s;

    alu_ctl_decode u_decode (
        .instr    (instr),
        .ctl_o    (dec_ctl_s),
        .b_sel_o  (dec_bsel_s),
        .a_zero_o (dec_a_zero_s),
        .shift_o  (dec_shift_s),
        .legal_o  (dec_legal_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: illegal ops skip EXEC; DONE never accepts a new bundle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = dec_legal_s ? ST_EXEC : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (count_q <= 5'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        in_ready_s  = (state_q == ST_IDLE);
        out_valid_s = (state_q == ST_DONE);
    end

    // Datapath next values: issue on accept, feed shifts back, capture the result.
    always_comb begin
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_ctl_d = alu_ctl_q;
        count_d   = count_q;
        res_d     = res_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && dec_legal_s) begin
                    alu_a_d   = dec_a_zero_s ? {DATA_W{1'b0}} : rs_val;
                    alu_ctl_d = dec_ctl_s;
                    count_d   = dec_shift_s ? instr[10:6] : 5'd0;
                    case (dec_bsel_s)
                        B_SEXT:  alu_b_d = ext_imm(instr[15:0], 1'b1);
                        B_ZEXT:  alu_b_d = ext_imm(instr[15:0], 1'b0);
                        default: alu_b_d = rt_val;
                    endcase
                end else if (in_valid) begin
                    res_d     = {DATA_W{1'b0}};
                    zero_d    = 1'b0;
                    illegal_d = 1'b1;
                end else begin
                    count_d = count_q;
                end
            end
            ST_EXEC: begin
                if (count_q > 5'd1) begin
                    alu_b_d = alu_result;
                    count_d = count_q - 5'd1;
                end else begin
                    res_d     = alu_result;
                    zero_d    = alu_zero;
                    illegal_d = 1'b0;
                    count_d   = 5'd0;
                end
            end
            default: count_d = count_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q   <= {DATA_W{1'b0}};
            alu_b_q   <= {DATA_W{1'b0}};
            alu_ctl_q <= 4'b0000;
            count_q   <= 5'd0;
            res_q     <= {DATA_W{1'b0}};
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_ctl_q <= alu_ctl_d;
            count_q   <= count_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_s;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctl     = alu_ctl_q;
    assign out_result  = res_q;
    assign out_zero    = zero_q;
    assign out_illegal = illegal_q;

endmodule
